// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: streams bitstream words into parallel ccff chains with config_enable/isolation sequencing
module ccff_bitstream_loader #(
   parameter int NUM_CHAINS = 12,
   parameter int CHAIN_LEN  = 1024,
   parameter int CNT_W      = 16,
   parameter int SETUP_CYC  = 4,
   parameter int HOLD_CYC   = 4,
   parameter int STALL_MAX  = 255
) (
   input  logic                  prog_clk,
   input  logic                  pReset_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [NUM_CHAINS-1:0] bs_data,
   input  logic                  bs_valid,
   output logic                  bs_ready,
   output logic [NUM_CHAINS-1:0] ccff_head,
   output logic                  ccff_shift,
   output logic                  config_enable,
   output logic                  io_isol_n,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [CNT_W-1:0]      words_loaded
);
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE, S_ERR} state_t;
   state_t r_state, w_next;
   logic [CNT_W-1:0] r_cnt, w_cnt, r_stall, w_stall, r_words, w_words;
   logic [NUM_CHAINS-1:0] r_head;
   logic r_shift, w_xfer, w_idle;
   // next-state, counters and status decode; abort drops any same-cycle transfer
   always_comb begin
      w_idle        = r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR;
      busy          = !w_idle;
      config_enable = !w_idle;
      io_isol_n     = r_state == S_DONE;
      done          = r_state == S_DONE;
      error         = r_state == S_ERR;
      bs_ready      = r_state == S_SHIFT && r_words < CNT_W'(CHAIN_LEN);
      w_xfer        = bs_valid && bs_ready && !abort;
      w_next        = r_state;
      w_cnt         = r_cnt;
      w_stall       = r_stall;
      w_words       = r_words;
      if (w_idle) begin
         if (start) begin
            w_next  = S_SETUP;
            w_cnt   = '0;
            w_stall = '0;
            w_words = '0;
         end
      end else if (abort) begin
         w_next = S_ERR;
      end else begin
         case (r_state)
            S_SETUP: begin
               w_next = r_cnt == CNT_W'(SETUP_CYC - 1) ? S_SHIFT : S_SETUP;
               w_cnt  = r_cnt == CNT_W'(SETUP_CYC - 1) ? '0 : r_cnt + 1'b1;
            end
            S_SHIFT: begin
               if (w_xfer) begin
                  w_words = r_words + 1'b1;
                  w_stall = '0;
                  w_next  = r_words == CNT_W'(CHAIN_LEN - 1) ? S_HOLD : S_SHIFT;
                  w_cnt   = '0;
               end else if (!bs_valid) begin
                  w_stall = r_stall + 1'b1;
                  w_next  = r_stall == CNT_W'(STALL_MAX - 1) ? S_ERR : S_SHIFT;
               end
            end
            S_HOLD: begin
               w_next = r_cnt == CNT_W'(HOLD_CYC - 1) ? S_DONE : S_HOLD;
               w_cnt  = r_cnt + 1'b1;
            end
            default: w_next = r_state;
         endcase
      end
      ccff_head    = r_head;
      ccff_shift   = r_shift;
      words_loaded = r_words;
   end
   // state and counter registers; async reset returns to isolated idle
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_stall <= '0;
         r_words <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt;
         r_stall <= w_stall;
         r_words <= w_words;
      end
   end
   // chain head data and shift pulse, one cycle after the accepting edge
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         r_head  <= '0;
         r_shift <= 1'b0;
      end else begin
         r_shift <= w_xfer;
         if (w_xfer) r_head <= bs_data;
      end
   end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: directed checks of load, throttle, stall, abort, reset and reload
module tb_ccff_bitstream_loader;
   localparam int NC = 12;
   localparam int CW = 16;
   logic prog_clk = 1'b0;
   logic pReset_n, start, abort, bs_valid, bs_ready, ccff_shift, config_enable, io_isol_n, busy, done, error;
   logic [NC-1:0] bs_data, ccff_head;
   logic [CW-1:0] words_loaded;
   int checks = 0;
   int errors = 0;
   int nshift, done_at;
   always #5 prog_clk = ~prog_clk;
   ccff_bitstream_loader #(
      .NUM_CHAINS(NC), .CHAIN_LEN(8), .CNT_W(CW), .SETUP_CYC(4), .HOLD_CYC(4), .STALL_MAX(5)
   ) dut (
      .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .abort(abort),
      .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready), .ccff_head(ccff_head),
      .ccff_shift(ccff_shift), .config_enable(config_enable), .io_isol_n(io_isol_n),
      .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
   );
   task automatic step;
      @(posedge prog_clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_ready"}, bs_ready, 0);
      chk({tag, "_head"}, ccff_head, 0);
      chk({tag, "_shift"}, ccff_shift, 0);
      chk({tag, "_cfg"}, config_enable, 0);
      chk({tag, "_isol"}, io_isol_n, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_words"}, words_loaded, 0);
   endtask
   initial begin
      pReset_n = 1'b0; start = 1'b0; abort = 1'b0; bs_valid = 1'b0; bs_data = '0;
      #12;
      chk_reset("rst");
      #4 pReset_n = 1'b1;
      step;
      chk_reset("idle");
      start = 1'b1; bs_valid = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         step;
         start = 1'b0;
         chk("nom_cfg", config_enable, k <= 16);
         chk("nom_shift", ccff_shift, k >= 6 && k <= 13);
         if (k >= 6 && k <= 13) chk("nom_head", ccff_head, k - 5);
         chk("nom_ready", bs_ready, k >= 5 && k <= 12);
         chk("nom_words", words_loaded, k < 6 ? 0 : (k > 13 ? 8 : k - 5));
         chk("nom_done", done, k == 17);
         chk("nom_isol", io_isol_n, k == 17);
         bs_data = NC'(k >= 4 ? k - 4 : 0);
      end
      bs_valid = 1'b0;
      step;
      chk("done_hold", done, 1);
      chk("done_busy", busy, 0);
      chk("done_words", words_loaded, 8);
      chk("done_err", error, 0);
      start = 1'b1; nshift = 0; done_at = 0;
      for (int k = 1; k <= 30; k++) begin
         step;
         start = 1'b0;
         if (k == 1) begin
            chk("reload_done", done, 0);
            chk("reload_words", words_loaded, 0);
            chk("reload_cfg", config_enable, 1);
         end
         chk("reload_isol", io_isol_n, k >= 24);
         if (ccff_shift) begin
            chk("thr_head", ccff_head, nshift + 1);
            nshift++;
         end
         if (k >= 6 && k <= 21) chk("thr_shift", ccff_shift, k % 2 == 0 && k <= 20);
         if (done && done_at == 0) done_at = k;
         bs_valid = k >= 5 && (k - 5) % 2 == 0 && (k - 5) / 2 < 8;
         bs_data = NC'(k >= 5 ? (k - 5) / 2 + 1 : 0);
      end
      chk("thr_count", nshift, 8);
      chk("thr_done_at", done_at, 24);
      chk("thr_words", words_loaded, 8);
      bs_valid = 1'b0;
      start = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         step;
         start = 1'b0;
         bs_valid = k >= 5 && k <= 7;
         bs_data = NC'(k >= 4 ? k - 4 : 0);
         if (k == 8) begin
            chk("stall_shift3", ccff_shift, 1);
            chk("stall_head3", ccff_head, 3);
         end
         if (k == 9) begin
            chk("stall_noshift", ccff_shift, 0);
            chk("stall_headhold", ccff_head, 3);
         end
         chk("stall_err", error, k == 13);
      end
      chk("stall_words", words_loaded, 3);
      chk("stall_isol", io_isol_n, 0);
      chk("stall_ready", bs_ready, 0);
      chk("stall_cfg", config_enable, 0);
      chk("stall_busy", busy, 0);
      abort = 1'b1;
      step;
      chk("err_abort_err", error, 1);
      chk("err_abort_words", words_loaded, 3);
      start = 1'b1;
      step;
      start = 1'b0; abort = 1'b0;
      chk("start_wins_busy", busy, 1);
      chk("start_wins_err", error, 0);
      chk("start_wins_words", words_loaded, 0);
      bs_valid = 1'b1; bs_data = '0;
      for (int k = 2; k <= 10; k++) begin
         step;
         start = k == 2;
         bs_data = NC'(k >= 4 ? k - 4 : 0);
         if (k == 4) chk("ign_start_ready4", bs_ready, 0);
         if (k == 5) chk("ign_start_ready5", bs_ready, 1);
         if (k == 9) begin
            chk("abort_pre_shift", ccff_shift, 1);
            chk("abort_pre_head", ccff_head, 4);
            chk("abort_pre_words", words_loaded, 4);
            abort = 1'b1;
         end
         if (k == 10) begin
            chk("abort_err", error, 1);
            chk("abort_noshift", ccff_shift, 0);
            chk("abort_head", ccff_head, 4);
            chk("abort_words", words_loaded, 4);
            chk("abort_ready", bs_ready, 0);
            abort = 1'b0;
         end
      end
      start = 1'b1; bs_valid = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step;
         start = 1'b0;
         bs_data = NC'(k >= 4 ? k - 4 : 0);
      end
      chk("mid_head2", ccff_head, 2);
      chk("mid_words2", words_loaded, 2);
      #2 pReset_n = 1'b0;
      #1;
      chk_reset("mid_rst");
      bs_valid = 1'b0;
      #2 pReset_n = 1'b1;
      step;
      chk_reset("post_rst");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
